// File: rtl/openram_march_bist.sv
// openram_march_bist: March C- self-test engine for a single OpenRAM macro.
// Runs M0..M5 over the full address space with a latched data background,
// compares read data through a READ_LAT-deep pipeline and counts mismatches.
// Define OPENRAM_BIST_ERR_LOG_EN to add a first-mismatch capture log.

module openram_march_bist #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DUAL_PORT = 1,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   background,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    fail_count,
  output logic                csb0,
  output logic                web0,
  output logic [DATA_W/8-1:0] wmask0,
  output logic [ADDR_W-1:0]   addr0,
  output logic [DATA_W-1:0]   din0,
  input  logic [DATA_W-1:0]   dout0,
  output logic                csb1,
  output logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   dout1
`ifdef OPENRAM_BIST_ERR_LOG_EN
  ,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [2:0]          err_element,
  output logic [DATA_W-1:0]   err_expected,
  output logic [DATA_W-1:0]   err_actual
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d;     // 0: first op at this address, 1: second
  logic [1:0]        drain_q;
  logic [DATA_W-1:0] bg_q;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic              pass_q, pass_d;

  // Read-compare pipeline, stage READ_LAT-1 lines up with valid dout
  logic              pipe_vld [READ_LAT];
  logic              pipe_p1  [READ_LAT];
  logic [DATA_W-1:0] pipe_exp [READ_LAT];
`ifdef OPENRAM_BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] pipe_addr [READ_LAT];
  logic [2:0]        pipe_elem [READ_LAT];
`endif

  logic              start_ok, abort_now, is_desc, last_op, addr_end, run_last;
  logic              is_wr, use_p1, rd_issue, mismatch;
  logic [DATA_W-1:0] rd_exp, wr_data, cmp_act;

  assign start_ok  = (state_q == StIdle) && start;
  assign abort_now = ((state_q == StRun) || (state_q == StDrain)) && abort;
  assign is_desc   = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign last_op   = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
  assign addr_end  = is_desc ? (addr_q == '0) : (addr_q == '1);
  assign run_last  = (elem_q == 3'd5) && addr_end;
  assign is_wr     = (elem_q == 3'd0) || op_q;
  assign use_p1    = (DUAL_PORT != 0) && (elem_q == 3'd5);
  assign rd_issue  = (state_q == StRun) && !is_wr;
  // M2/M4 read the inverted background, M1/M3 write it
  assign rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~bg_q : bg_q;
  assign wr_data   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~bg_q : bg_q;
  assign cmp_act   = pipe_p1[READ_LAT-1] ? dout1 : dout0;
  assign mismatch  = pipe_vld[READ_LAT-1] && (cmp_act != pipe_exp[READ_LAT-1]) && !abort_now;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun: begin
        if (abort)         state_d = StIdle;
        else if (run_last) state_d = StDrain;
      end
      StDrain: begin
        if (abort)                              state_d = StIdle;
        else if (drain_q == 2'(READ_LAT - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // SRAM port drive and status outputs
  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    csb1   = 1'b1;
    addr1  = '0;
    if (state_q == StRun) begin
      if (is_wr) begin
        csb0   = 1'b0;
        web0   = 1'b0;
        wmask0 = '1;
        addr0  = addr_q;
        din0   = wr_data;
      end else if (use_p1) begin
        csb1  = 1'b0;
        addr1 = addr_q;
      end else begin
        csb0  = 1'b0;
        addr0 = addr_q;
      end
    end
    busy = (state_q == StRun) || (state_q == StDrain);
    done = (state_q == StDone);
  end

  // Element / address / op sequencing through the March elements
  always_comb begin
    elem_d = elem_q;
    addr_d = addr_q;
    op_d   = op_q;
    if (start_ok) begin
      elem_d = 3'd0;
      addr_d = '0;
      op_d   = 1'b0;
    end else if (state_q == StRun) begin
      if (!last_op) begin
        op_d = 1'b1;
      end else begin
        op_d = 1'b0;
        if (addr_end) begin
          elem_d = elem_q + 3'd1;
          // M3 and M4 are descending and start from the top
          addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
        end else begin
          addr_d = is_desc ? addr_q - 1'b1 : addr_q + 1'b1;
        end
      end
    end
  end

  // Saturating mismatch count and pass flag
  always_comb begin
    fail_d = fail_q;
    pass_d = pass_q;
    if (start_ok) begin
      fail_d = '0;
      pass_d = 1'b0;
    end else begin
      if (mismatch && (fail_q != '1)) fail_d = fail_q + CNT_W'(1);
      if (abort_now) pass_d = 1'b0;
      else if ((state_q == StDrain) && (state_d == StDone)) pass_d = (fail_d == '0);
    end
  end

  // Sequencer, background and result registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      elem_q  <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      drain_q <= '0;
      bg_q    <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      drain_q <= (state_q == StDrain) ? drain_q + 2'd1 : 2'd0;
      if (start_ok) bg_q <= background;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  // Expected-data pipeline; abort discards outstanding compares
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || abort_now) begin
      for (int i = 0; i < int'(READ_LAT); i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_p1[i]  <= 1'b0;
        pipe_exp[i] <= '0;
`ifdef OPENRAM_BIST_ERR_LOG_EN
        pipe_addr[i] <= '0;
        pipe_elem[i] <= '0;
`endif
      end
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_p1[0]  <= use_p1;
      pipe_exp[0] <= rd_exp;
`ifdef OPENRAM_BIST_ERR_LOG_EN
      pipe_addr[0] <= addr_q;
      pipe_elem[0] <= elem_q;
`endif
      for (int i = 1; i < int'(READ_LAT); i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_p1[i]  <= pipe_p1[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
`ifdef OPENRAM_BIST_ERR_LOG_EN
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_elem[i] <= pipe_elem[i-1];
`endif
      end
    end
  end

  assign pass       = pass_q;
  assign fail_count = fail_q;

`ifdef OPENRAM_BIST_ERR_LOG_EN
  logic              err_valid_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [2:0]        err_elem_q;
  logic [DATA_W-1:0] err_exp_q, err_act_q;

  // First-mismatch capture, cleared by an accepted start
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_elem_q  <= '0;
      err_exp_q   <= '0;
      err_act_q   <= '0;
    end else if (start_ok) begin
      err_valid_q <= 1'b0;
    end else if (mismatch && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= pipe_addr[READ_LAT-1];
      err_elem_q  <= pipe_elem[READ_LAT-1];
      err_exp_q   <= pipe_exp[READ_LAT-1];
      err_act_q   <= cmp_act;
    end
  end

  assign err_valid    = err_valid_q;
  assign err_addr     = err_addr_q;
  assign err_element  = err_elem_q;
  assign err_expected = err_exp_q;
  assign err_actual   = err_act_q;
`endif

endmodule

// File: tb/tb_openram_march_bist.sv
// Bench for openram_march_bist: two instances (dual-port/READ_LAT=1/16-bit count and
// single-port/READ_LAT=3/2-bit count) against behavioural SRAMs with stuck-at faults.
module tb_openram_march_bist;

  localparam int Depth = 16;
  localparam int LatA  = 1;
  localparam int LatB  = 3;
  localparam int Limit = 175;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        wb_rst_i, start, abort;
  logic [31:0] background;

  logic        busy_a, done_a, pass_a, csb0_a, web0_a, csb1_a;
  logic [15:0] fail_count_a;
  logic [3:0]  wmask0_a, addr0_a, addr1_a;
  logic [31:0] din0_a, dout0_a, dout1_a;
  logic        busy_b, done_b, pass_b, csb0_b, web0_b, csb1_b;
  logic [1:0]  fail_count_b;
  logic [3:0]  wmask0_b, addr0_b, addr1_b;
  logic [31:0] din0_b, dout0_b, dout1_b;
`ifdef OPENRAM_BIST_ERR_LOG_EN
  logic        err_valid_a, err_valid_b;
  logic [3:0]  err_addr_a, err_addr_b;
  logic [2:0]  err_element_a, err_element_b;
  logic [31:0] err_expected_a, err_expected_b, err_actual_a, err_actual_b;
`endif

  openram_march_bist #(
    .DATA_W(32), .ADDR_W(4), .DUAL_PORT(1), .READ_LAT(LatA), .CNT_W(16)
  ) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
    .background(background), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fail_count_a), .csb0(csb0_a), .web0(web0_a), .wmask0(wmask0_a),
    .addr0(addr0_a), .din0(din0_a), .dout0(dout0_a), .csb1(csb1_a), .addr1(addr1_a),
    .dout1(dout1_a)
`ifdef OPENRAM_BIST_ERR_LOG_EN
    , .err_valid(err_valid_a), .err_addr(err_addr_a), .err_element(err_element_a),
    .err_expected(err_expected_a), .err_actual(err_actual_a)
`endif
  );

  openram_march_bist #(
    .DATA_W(32), .ADDR_W(4), .DUAL_PORT(0), .READ_LAT(LatB), .CNT_W(2)
  ) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
    .background(background), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fail_count_b), .csb0(csb0_b), .web0(web0_b), .wmask0(wmask0_b),
    .addr0(addr0_b), .din0(din0_b), .dout0(dout0_b), .csb1(csb1_b), .addr1(addr1_b),
    .dout1(dout1_b)
`ifdef OPENRAM_BIST_ERR_LOG_EN
    , .err_valid(err_valid_b), .err_addr(err_addr_b), .err_element(err_element_b),
    .err_expected(err_expected_b), .err_actual(err_actual_b)
`endif
  );

  // Stuck-at fault list shared by both SRAM models and the reference model
  int f_n;
  int f_addr [2];
  int f_bit  [2];
  bit f_val  [2];

  function automatic logic [31:0] apply_f(input int a, input logic [31:0] d);
    logic [31:0] r = d;
    for (int i = 0; i < f_n; i++) if (f_addr[i] == a) r[f_bit[i]] = f_val[i];
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Behavioural SRAMs: read data appears READ_LAT cycles after the read cycle
  logic [31:0] mem_a [Depth];
  logic [31:0] mem_b [Depth];
  logic [31:0] d0_a, d1_a;
  logic [31:0] d0_b [LatB];

  always @(posedge clk) begin
    if (!csb0_a && !web0_a) mem_a[addr0_a] <= merge(mem_a[addr0_a], din0_a, wmask0_a);
    d0_a <= (!csb0_a && web0_a) ? apply_f(int'(addr0_a), mem_a[addr0_a]) : 32'h0;
    d1_a <= !csb1_a ? apply_f(int'(addr1_a), mem_a[addr1_a]) : 32'h0;
  end

  always @(posedge clk) begin
    if (!csb0_b && !web0_b) mem_b[addr0_b] <= merge(mem_b[addr0_b], din0_b, wmask0_b);
    d0_b[0] <= (!csb0_b && web0_b) ? apply_f(int'(addr0_b), mem_b[addr0_b]) : 32'h0;
    d0_b[1] <= d0_b[0];
    d0_b[2] <= d0_b[1];
  end

  assign dout0_a = d0_a;
  assign dout1_a = d1_a;
  assign dout0_b = d0_b[LatB-1];
  assign dout1_b = 32'h0;

  // March C- as an operation list
  typedef struct {
    bit          we;
    int          addr;
    logic [31:0] data;
    int          elem;
  } op_t;

  op_t ops[$];
  int  n_ops  [6] = '{1, 2, 2, 2, 2, 1};
  bit  op_wr  [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit  op_inv [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  int          exp_n;
  bit          first_v;
  int          first_addr, first_elem;
  logic [31:0] first_exp, first_act;

  function automatic void build_ops(input logic [31:0] bg);
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < Depth; k++) begin
        for (int j = 0; j < n_ops[e]; j++) begin
          op_t o;
          o.we   = op_wr[e][j];
          o.addr = (e == 3 || e == 4) ? Depth - 1 - k : k;
          o.data = op_inv[e][j] ? ~bg : bg;
          o.elem = e;
          ops.push_back(o);
        end
      end
    end
  endfunction

  function automatic void run_model();
    logic [31:0] m [Depth];
    logic [31:0] act;
    exp_n   = 0;
    first_v = 1'b0;
    for (int i = 0; i < ops.size(); i++) begin
      if (ops[i].we) begin
        m[ops[i].addr] = ops[i].data;
      end else begin
        act = apply_f(ops[i].addr, m[ops[i].addr]);
        if (act !== ops[i].data) begin
          if (!first_v) begin
            first_v    = 1'b1;
            first_addr = ops[i].addr;
            first_elem = ops[i].elem;
            first_exp  = ops[i].data;
            first_act  = act;
          end
          exp_n++;
        end
      end
    end
  endfunction

  function automatic bit op_ok(input bit dp, input int c, input logic cs0, input logic we0,
                               input logic [3:0] m, input logic [3:0] a0,
                               input logic [31:0] d0, input logic cs1, input logic [3:0] a1);
    op_t o = ops[c-1];
    if (o.we)
      return cs0 === 1'b0 && we0 === 1'b0 && m === 4'hf && a0 === 4'(o.addr) &&
             d0 === o.data && cs1 === 1'b1;
    if (dp && o.elem == 5) return cs0 === 1'b1 && cs1 === 1'b0 && a1 === 4'(o.addr);
    return cs0 === 1'b0 && we0 === 1'b1 && a0 === 4'(o.addr) && cs1 === 1'b1;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ctl_a", {csb0_a, web0_a, csb1_a, busy_a, done_a, pass_a}, 6'b111000);
    check_eq("rst_dat_a", {wmask0_a, addr0_a, din0_a, addr1_a, fail_count_a}, 64'h0);
    check_eq("rst_ctl_b", {csb0_b, web0_b, csb1_b, busy_b, done_b, pass_b}, 6'b111000);
    check_eq("rst_dat_b", {wmask0_b, addr0_b, din0_b, addr1_b, fail_count_b}, 64'h0);
  endtask

  // One run from start; abort_at / rst_at < 0 disable those events
  task automatic run(input logic [31:0] bg, input bit both, input int abort_at, input int rst_at);
    int dc_a = 0, dc_b = 0, nd_a = 0, nd_b = 0, nb_a = 0, nb_b = 0;
    int bad_a = 0, bad_b = 0, p1_b = 0;
    logic [15:0] hold_a = '0;
    logic [1:0]  hold_b = '0;
    build_ops(bg);
    run_model();
    background = bg;
    start      = 1'b1;
    abort      = both;
    @(posedge clk);
    #1;
    start      = 1'b0;
    background = $urandom;  // must not matter once latched
    for (int c = 1; c <= Limit; c++) begin
      abort    = (c == abort_at);
      wb_rst_i = (c == rst_at);
      start    = (c == 30);  // ignored while busy
      @(negedge clk);
      if (done_a) begin nd_a++; if (dc_a == 0) dc_a = c; end
      if (done_b) begin nd_b++; if (dc_b == 0) dc_b = c; end
      if (busy_a) nb_a++;
      if (busy_b) nb_b++;
      if (!csb1_b) p1_b++;
      if (c <= 10 * Depth && (abort_at < 0 || c <= abort_at) && (rst_at < 0 || c <= rst_at)) begin
        if (!op_ok(1'b1, c, csb0_a, web0_a, wmask0_a, addr0_a, din0_a, csb1_a, addr1_a)) bad_a++;
        if (!op_ok(1'b0, c, csb0_b, web0_b, wmask0_b, addr0_b, din0_b, csb1_b, addr1_b)) bad_b++;
      end
      if (c == abort_at + 1 && abort_at >= 0) begin
        check_eq("abort_a", {busy_a, csb0_a, csb1_a, pass_a, done_a}, 5'b01100);
        check_eq("abort_b", {busy_b, csb0_b, csb1_b, pass_b, done_b}, 5'b01100);
        hold_a = fail_count_a;
        hold_b = fail_count_b;
      end
      if (c == rst_at + 1 && rst_at >= 0) check_reset_outputs();
      @(posedge clk);
      #1;
    end
    abort    = 1'b0;
    wb_rst_i = 1'b0;
    start    = 1'b0;
    check_eq("trace_a", bad_a, 0);
    check_eq("trace_b", bad_b, 0);
    check_eq("csb1_b_idle", p1_b, 0);
    if (abort_at >= 0 || rst_at >= 0) begin
      check_eq("no_done_a", nd_a, 0);
      check_eq("no_done_b", nd_b, 0);
      if (abort_at >= 0) begin
        check_eq("hold_fc_a", fail_count_a, hold_a);
        check_eq("hold_fc_b", fail_count_b, hold_b);
      end
    end else begin
      check_eq("done_cyc_a", dc_a, 10 * Depth + LatA + 1);
      check_eq("done_cyc_b", dc_b, 10 * Depth + LatB + 1);
      check_eq("done_cnt_a", nd_a, 1);
      check_eq("done_cnt_b", nd_b, 1);
      check_eq("busy_len_a", nb_a, 10 * Depth + LatA);
      check_eq("busy_len_b", nb_b, 10 * Depth + LatB);
      check_eq("fail_cnt_a", fail_count_a, exp_n);
      check_eq("fail_cnt_b", fail_count_b, (exp_n > 3) ? 3 : exp_n);
      check_eq("pass_a", pass_a, exp_n == 0);
      check_eq("pass_b", pass_b, exp_n == 0);
`ifdef OPENRAM_BIST_ERR_LOG_EN
      check_eq("err_valid_a", err_valid_a, first_v);
      if (first_v) begin
        check_eq("err_addr_a", err_addr_a, first_addr);
        check_eq("err_elem_a", err_element_a, first_elem);
        check_eq("err_exp_a", err_expected_a, first_exp);
        check_eq("err_act_a", err_actual_a, first_act);
      end
`endif
    end
  endtask

  task automatic set_random_faults();
    f_n = $urandom_range(0, 2);
    for (int i = 0; i < 2; i++) begin
      f_addr[i] = $urandom_range(0, Depth - 1);
      f_bit[i]  = $urandom_range(0, 31);
      f_val[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    wb_rst_i   = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    background = '0;
    f_n        = 0;
    repeat (3) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    // Clean run, zero background
    run(32'h0, 1'b0, -1, -1);

    // Stuck-at-1 on bit 3 of address 5
    f_n = 1; f_addr[0] = 5; f_bit[0] = 3; f_val[0] = 1'b1;
    run(32'h0, 1'b0, -1, -1);
    check_eq("sa1_count", fail_count_a, 3);

    // Random backgrounds and fault sets; start+abort together in some
    for (int r = 0; r < 5; r++) begin
      set_random_faults();
      run($urandom, 1'($urandom_range(0, 1)), -1, -1);
    end

    // Abort mid-run, then a clean run
    f_n = 0;
    run($urandom, 1'b0, 50, -1);
    run($urandom, 1'b0, -1, -1);

    // Reset mid-run, then a clean run
    f_n = 1; f_addr[0] = 9; f_bit[0] = 17; f_val[0] = 1'b0;
    run($urandom, 1'b0, -1, 80);
    f_n = 0;
    run($urandom, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
